// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush generation with a four-state wait FSM.
// Optional stall-cycle counter enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_use_hazard,
    input  logic       branch_taken,
    input  logic       imem_ready,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    input  logic       ex_busy,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       id_ex_stall,
    output logic       ex_mem_stall,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       mem_wb_flush,
    output logic [1:0] ctrl_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        EX_WAIT  = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   mw;

    assign mw         = dmem_req & ~dmem_ready;
    assign ctrl_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Priority: memory wait, EX busy, branch redirect, load-use, fetch bubble.
    // Outputs are forced quiet while reset is held so nothing leaks during async reset.
    always_comb begin
        state_next   = RUN;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rst) begin
            if (mw) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
                state_next   = MEM_WAIT;
            end else if (ex_busy) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
                state_next   = EX_WAIT;
            end else if (branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                state_next   = REDIRECT;
            end else if (load_use_hazard && (state != REDIRECT)) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
                state_next   = RUN;
            end else if (!imem_ready || (state == REDIRECT)) begin
                pc_stall     = ~imem_ready;
                if_id_flush  = 1'b1;
                state_next   = imem_ready ? RUN : REDIRECT;
            end
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'd0;
        end else if (pc_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl; packs outputs as {4 stalls, 4 flushes, state}.
// Define PIPE_HAZARD_CTRL_PERF_EN to also check the stall-cycle counter.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_use_hazard, branch_taken, imem_ready;
    logic       dmem_req, dmem_ready, ex_busy;
    logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0] ctrl_state;
    logic [9:0] obs;
    int         vectors = 0;
    int         miscompares = 0;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] cnt_before;
`endif

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .ex_busy(ex_busy),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .ctrl_state(ctrl_state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    assign obs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, ctrl_state};

    // Each vector: drive at the falling edge, sample 1ns later, state advances on the next rise.
    task automatic drive(input logic lu, input logic br, input logic im,
                         input logic dq, input logic dr, input logic eb);
        @(negedge clk);
        load_use_hazard = lu; branch_taken = br; imem_ready = im;
        dmem_req = dq; dmem_ready = dr; ex_busy = eb;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        load_use_hazard = 1; branch_taken = 1; imem_ready = 0;
        dmem_req = 1; dmem_ready = 0; ex_busy = 1;
        #2;
        vectors++;
        if (obs !== 10'b0000_0000_00) begin
            $display("[TB] FAIL reset_async obs=%b exp=%b", obs, 10'b0);
            miscompares++;
        end
        drive(1, 1, 0, 1, 0, 1);
        vectors++;
        if (obs !== 10'b0000_0000_00) begin
            $display("[TB] FAIL reset_held obs=%b exp=%b", obs, 10'b0);
            miscompares++;
        end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        vectors++;
        if (stall_cycles !== 32'd0) begin
            $display("[TB] FAIL reset_cnt obs=%0d exp=0", stall_cycles);
            miscompares++;
        end
`endif
        drive(0, 0, 1, 0, 0, 0);
        rst = 1'b0;
        #1;
        vectors++;
        if (obs !== 10'b0000_0000_00) begin
            $display("[TB] FAIL idle_run obs=%b exp=%b", obs, 10'b0);
            miscompares++;
        end
    endtask

    task automatic test_load_use;
        drive(1, 0, 1, 0, 0, 0);
        vectors++;
        if (obs !== 10'b1100_0100_00) begin
            $display("[TB] FAIL load_use obs=%b exp=%b", obs, 10'b1100_0100_00);
            miscompares++;
        end
        drive(0, 0, 1, 0, 0, 0);
        vectors++;
        if (obs !== 10'b0000_0000_00) begin
            $display("[TB] FAIL load_use_after obs=%b exp=%b", obs, 10'b0);
            miscompares++;
        end
    endtask

    task automatic test_branch;
        drive(1, 1, 1, 0, 0, 0);
        vectors++;
        if (obs !== 10'b0000_1100_00) begin
            $display("[TB] FAIL branch obs=%b exp=%b", obs, 10'b0000_1100_00);
            miscompares++;
        end
        drive(1, 0, 1, 0, 0, 0);
        vectors++;
        if (obs !== 10'b0000_1000_11) begin
            $display("[TB] FAIL branch_redirect obs=%b exp=%b", obs, 10'b0000_1000_11);
            miscompares++;
        end
        drive(0, 0, 1, 0, 0, 0);
        vectors++;
        if (obs !== 10'b0000_0000_00) begin
            $display("[TB] FAIL branch_done obs=%b exp=%b", obs, 10'b0);
            miscompares++;
        end
    endtask

    task automatic test_mem_wait;
        drive(0, 0, 1, 1, 0, 1);
        vectors++;
        if (obs !== 10'b1111_0001_00) begin
            $display("[TB] FAIL mem_wait_1 obs=%b exp=%b", obs, 10'b1111_0001_00);
            miscompares++;
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 1, 0, 1);
            vectors++;
            if (obs !== 10'b1111_0001_01) begin
                $display("[TB] FAIL mem_wait_held obs=%b exp=%b", obs, 10'b1111_0001_01);
                miscompares++;
            end
        end
        drive(0, 0, 1, 1, 1, 1);
        vectors++;
        if (obs !== 10'b1110_0010_01) begin
            $display("[TB] FAIL mem_to_ex obs=%b exp=%b", obs, 10'b1110_0010_01);
            miscompares++;
        end
        drive(0, 0, 1, 0, 0, 0);
        vectors++;
        if (obs !== 10'b0000_0000_10) begin
            $display("[TB] FAIL ex_wait_exit obs=%b exp=%b", obs, 10'b0000_0000_10);
            miscompares++;
        end
        drive(0, 0, 1, 0, 0, 0);
        vectors++;
        if (obs !== 10'b0000_0000_00) begin
            $display("[TB] FAIL mem_wait_done obs=%b exp=%b", obs, 10'b0);
            miscompares++;
        end
    endtask

    task automatic test_ex_wait_branch;
        drive(0, 1, 1, 0, 0, 1);
        vectors++;
        if (obs !== 10'b1110_0010_00) begin
            $display("[TB] FAIL exbr_1 obs=%b exp=%b", obs, 10'b1110_0010_00);
            miscompares++;
        end
        drive(0, 1, 1, 0, 0, 1);
        vectors++;
        if (obs !== 10'b1110_0010_10) begin
            $display("[TB] FAIL exbr_2 obs=%b exp=%b", obs, 10'b1110_0010_10);
            miscompares++;
        end
        drive(0, 1, 1, 0, 0, 0);
        vectors++;
        if (obs !== 10'b0000_1100_10) begin
            $display("[TB] FAIL exbr_service obs=%b exp=%b", obs, 10'b0000_1100_10);
            miscompares++;
        end
        drive(0, 0, 1, 0, 0, 0);
        vectors++;
        if (obs !== 10'b0000_1000_11) begin
            $display("[TB] FAIL exbr_redirect obs=%b exp=%b", obs, 10'b0000_1000_11);
            miscompares++;
        end
        drive(0, 0, 1, 0, 0, 0);
        vectors++;
        if (obs !== 10'b0000_0000_00) begin
            $display("[TB] FAIL exbr_done obs=%b exp=%b", obs, 10'b0);
            miscompares++;
        end
    endtask

    task automatic test_imem_wait;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        cnt_before = stall_cycles;
`endif
        drive(0, 1, 1, 0, 0, 0);
        vectors++;
        if (obs !== 10'b0000_1100_00) begin
            $display("[TB] FAIL imem_branch obs=%b exp=%b", obs, 10'b0000_1100_00);
            miscompares++;
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            vectors++;
            if (obs !== 10'b1000_1000_11) begin
                $display("[TB] FAIL imem_not_ready obs=%b exp=%b", obs, 10'b1000_1000_11);
                miscompares++;
            end
        end
        drive(0, 0, 1, 0, 0, 0);
        vectors++;
        if (obs !== 10'b0000_1000_11) begin
            $display("[TB] FAIL imem_ready_redirect obs=%b exp=%b", obs, 10'b0000_1000_11);
            miscompares++;
        end
        drive(0, 0, 1, 0, 0, 0);
        vectors++;
        if (obs !== 10'b0000_0000_00) begin
            $display("[TB] FAIL imem_done obs=%b exp=%b", obs, 10'b0);
            miscompares++;
        end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        vectors++;
        if (stall_cycles !== cnt_before + 32'd2) begin
            $display("[TB] FAIL imem_cnt obs=%0d exp=%0d", stall_cycles, cnt_before + 32'd2);
            miscompares++;
        end
`endif
        drive(1, 0, 0, 0, 0, 0);
        vectors++;
        if (obs !== 10'b1100_0100_00) begin
            $display("[TB] FAIL fetch_miss_loaduse obs=%b exp=%b", obs, 10'b1100_0100_00);
            miscompares++;
        end
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (obs !== 10'b1000_1000_00) begin
            $display("[TB] FAIL fetch_miss_run obs=%b exp=%b", obs, 10'b1000_1000_00);
            miscompares++;
        end
        drive(1, 0, 1, 0, 0, 0);
        vectors++;
        if (obs !== 10'b0000_1000_11) begin
            $display("[TB] FAIL redirect_ignores_lu obs=%b exp=%b", obs, 10'b0000_1000_11);
            miscompares++;
        end
        drive(0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_reset_mid_ex;
        drive(0, 0, 1, 0, 0, 1);
        vectors++;
        if (obs !== 10'b1110_0010_00) begin
            $display("[TB] FAIL rmid_ex1 obs=%b exp=%b", obs, 10'b1110_0010_00);
            miscompares++;
        end
        drive(0, 0, 1, 0, 0, 1);
        vectors++;
        if (obs !== 10'b1110_0010_10) begin
            $display("[TB] FAIL rmid_ex2 obs=%b exp=%b", obs, 10'b1110_0010_10);
            miscompares++;
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 10'b0000_0000_00) begin
            $display("[TB] FAIL rmid_async obs=%b exp=%b", obs, 10'b0);
            miscompares++;
        end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        vectors++;
        if (stall_cycles !== 32'd0) begin
            $display("[TB] FAIL rmid_cnt obs=%0d exp=0", stall_cycles);
            miscompares++;
        end
`endif
        drive(0, 0, 1, 0, 0, 1);
        vectors++;
        if (obs !== 10'b0000_0000_00) begin
            $display("[TB] FAIL rmid_held obs=%b exp=%b", obs, 10'b0);
            miscompares++;
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (obs !== 10'b1110_0010_00) begin
            $display("[TB] FAIL rmid_release obs=%b exp=%b", obs, 10'b1110_0010_00);
            miscompares++;
        end
        drive(0, 0, 1, 0, 0, 1);
        vectors++;
        if (obs !== 10'b1110_0010_10) begin
            $display("[TB] FAIL rmid_resume obs=%b exp=%b", obs, 10'b1110_0010_10);
            miscompares++;
        end
        drive(0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_ex_wait_branch();
        test_imem_wait();
        test_reset_mid_ex();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
